mult_shift_add_seq: RTL and testbench

- Sequential shift-and-add multiplier. It is the inverse-operation companion of the restoring-divider quotient datapath in the MDR (multiply/divide) unit.
- Accepts two data_in_t operands on a start strobe and iterates one multiplier bit per clock.
- Produces a double-width product, optionally signed, with a one-cycle done pulse.
- Sits beside the divider stages under the MDR top level and shares its package types.

---
 rtl/pkg_system_mdr.sv | 16 +
 rtl/mdr_cond_negate.sv | 18 +
 rtl/mult_shift_add_seq.sv | 131 +++++++++++++
 tb/tb_mult_shift_add_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_system_mdr.sv
// Shared types for the multiply/divide (MDR) unit: operand/result widths and multiplier states.
package pkg_system_mdr;

   localparam int unsigned DATA_WIDTH = 8;

   typedef logic [DATA_WIDTH-1:0]   data_in_t;
   typedef logic [2*DATA_WIDTH-1:0] data_out_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } mult_state_t;

endpackage

// File: rtl/mdr_cond_negate.sv
// Conditional two's-complement negation of a W-bit value; used for operand magnitudes
// and for re-applying the sign to the final product.
module mdr_cond_negate #(
   parameter int unsigned W = 8
) (
   input  logic         neg,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   always_comb begin
      dout = din;
      if (neg) begin
         dout = ~din + W'(1);
      end
   end

endmodule

// File: rtl/mult_shift_add_seq.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, sign/magnitude for
// signed operands, double-width registered product with a one-cycle done pulse.
module mult_shift_add_seq
   import pkg_system_mdr::*;
#(
   parameter int unsigned DW = DATA_WIDTH,
   parameter int unsigned CW = $clog2(DW)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
   input  logic          i_signed,
   input  logic [DW-1:0] i_multiplicand,
   input  logic [DW-1:0] i_multiplier,
   output logic [2*DW-1:0] o_product,
   output logic          o_busy,
   output logic          o_done
);

   mult_state_t state_q, state_d;

   logic [DW-1:0]   acc_q, acc_d;
   logic [DW-1:0]   mplier_q, mplier_d;
   logic [DW-1:0]   mcand_q, mcand_d;
   logic [CW-1:0]   count_q, count_d;
   logic            sign_q, sign_d;
   logic [2*DW-1:0] product_q, product_d;

   logic [DW-1:0]   mcand_mag;
   logic [DW-1:0]   mplier_mag;
   logic [2*DW-1:0] product_fix;
   logic [DW-1:0]   addend;
   logic [DW:0]     sum;

   // Magnitude of the most negative value fits unsigned in DW bits, so no extra bit is needed.
   mdr_cond_negate #(
      .W(DW)
   ) u_neg_mcand (
      .neg (i_signed & i_multiplicand[DW-1]),
      .din (i_multiplicand),
      .dout(mcand_mag)
   );

   mdr_cond_negate #(
      .W(DW)
   ) u_neg_mplier (
      .neg (i_signed & i_multiplier[DW-1]),
      .din (i_multiplier),
      .dout(mplier_mag)
   );

   mdr_cond_negate #(
      .W(2*DW)
   ) u_neg_product (
      .neg (sign_q),
      .din ({acc_q, mplier_q}),
      .dout(product_fix)
   );

   always_comb begin
      addend = mplier_q[0] ? mcand_q : '0;
      sum    = {1'b0, acc_q} + {1'b0, addend};
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mplier_d  = mplier_q;
      mcand_d   = mcand_q;
      count_d   = count_q;
      sign_d    = sign_q;
      product_d = product_q;

      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d  = RUN;
               acc_d    = '0;
               count_d  = '0;
               mcand_d  = mcand_mag;
               mplier_d = mplier_mag;
               sign_d   = i_signed & (i_multiplicand[DW-1] ^ i_multiplier[DW-1]);
            end
         end
         RUN: begin
            // {carry, acc, mplier} shifted right by one; product bits fill mplier from the top.
            acc_d    = sum[DW:1];
            mplier_d = {sum[0], mplier_q[DW-1:1]};
            count_d  = count_q + CW'(1);
            if (count_q == CW'(DW - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            product_d = product_fix;
            state_d   = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mplier_q  <= '0;
         mcand_q   <= '0;
         count_q   <= '0;
         sign_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mplier_q  <= mplier_d;
         mcand_q   <= mcand_d;
         count_q   <= count_d;
         sign_q    <= sign_d;
         product_q <= product_d;
      end
   end

   assign o_product = product_q;
   assign o_busy    = (state_q == RUN) || (state_q == FIX);
   assign o_done    = (state_q == DONE);

endmodule

// File: tb/tb_mult_shift_add_seq.sv
// Scoreboard bench for mult_shift_add_seq: stimulus pushes expected products, a negedge
// monitor pops and compares on every done pulse, also checking latency and busy width.
module tb_mult_shift_add_seq;
   import pkg_system_mdr::*;

   localparam int unsigned DW  = 8;
   localparam int unsigned LAT = DW + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            i_start;
   logic            i_signed;
   logic [DW-1:0]   a;
   logic [DW-1:0]   b;
   logic [2*DW-1:0] prod;
   logic            busy;
   logic            done;

   typedef struct {
      logic [2*DW-1:0] exp;
      int unsigned     start;
   } exp_t;

   exp_t            sb_q[$];
   int              errors   = 0;
   int              checks   = 0;
   int unsigned     cyc      = 0;
   int              n_done   = 0;
   int              busy_cnt = 0;
   logic            prev_done = 1'b0;
   logic [2*DW-1:0] prev_prod = '0;

   mult_shift_add_seq #(
      .DW(DW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (i_start),
      .i_signed      (i_signed),
      .i_multiplicand(a),
      .i_multiplier  (b),
      .o_product     (prod),
      .o_busy        (busy),
      .o_done        (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: plain integer multiplication of the (optionally signed) operand values.
   function automatic logic [2*DW-1:0] model(input logic sgn, input logic [DW-1:0] x,
                                            input logic [DW-1:0] y);
      longint      sx, sy, p;
      logic [63:0] pv;
      sx = longint'(x);
      sy = longint'(y);
      if (sgn && x[DW-1]) sx = sx - (longint'(1) << DW);
      if (sgn && y[DW-1]) sy = sy - (longint'(1) << DW);
      p  = sx * sy;
      pv = p;
      return pv[2*DW-1:0];
   endfunction

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_cnt = 0;
         end else begin
            if (busy) busy_cnt++;
            if (done) begin
               n_done++;
               check("done_single_cycle", {63'b0, prev_done}, 64'd0);
               check("busy_low_in_done", {63'b0, busy}, 64'd0);
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: got product 0x%0h, no request outstanding", prod);
               end else begin
                  e = sb_q.pop_front();
                  check("product", 64'(prod), 64'(e.exp));
                  check("done_latency", 64'(cyc - e.start), 64'(LAT));
                  check("busy_cycles", 64'(busy_cnt), 64'(LAT));
               end
               busy_cnt = 0;
            end else if (prod !== prev_prod && prod !== '0) begin
               checks++;
               errors++;
               $display("FAIL product_stable: got 0x%0h outside done, previous 0x%0h", prod,
                        prev_prod);
            end
         end
         prev_done = done;
         prev_prod = prod;
      end
   end

   task automatic start_op(input logic sgn, input logic [DW-1:0] x, input logic [DW-1:0] y,
                           input bit expect_it, input logic [2*DW-1:0] exp);
      @(negedge clk);
      i_start  = 1'b1;
      i_signed = sgn;
      a        = x;
      b        = y;
      if (expect_it) sb_q.push_back('{exp: exp, start: cyc + 1});
      @(posedge clk);
      #1;
      i_start  = 1'b0;
      i_signed = 1'($urandom);
      a        = DW'($urandom);
      b        = DW'($urandom);
   endtask

   // Returns at the negedge inside the DONE cycle.
   task automatic wait_done();
      int t = 0;
      forever begin
         @(negedge clk);
         if (done) break;
         t++;
         if (t > 40) begin
            checks++;
            errors++;
            $display("FAIL wait_done_timeout: got no done within 40 cycles, required one");
            break;
         end
      end
   endtask

   initial begin
      logic [DW-1:0] x, y;
      logic          s;
      int            n0;

      rst      = 1'b1;
      i_start  = 1'b0;
      i_signed = 1'b0;
      a        = '0;
      b        = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_product", 64'(prod), 64'd0);
      check("reset_busy", {63'b0, busy}, 64'd0);
      check("reset_done", {63'b0, done}, 64'd0);
      rst = 1'b0;

      start_op(1'b0, 8'd255, 8'd255, 1'b1, 16'hFE01);
      wait_done();
      start_op(1'b1, 8'h80, 8'h80, 1'b1, 16'h4000);
      wait_done();
      start_op(1'b1, 8'hFD, 8'd5, 1'b1, 16'hFFF1);
      wait_done();
      start_op(1'b1, 8'd127, 8'hFF, 1'b1, 16'hFF81);
      wait_done();
      start_op(1'b0, 8'd0, 8'hAB, 1'b1, 16'h0000);
      wait_done();

      // Starts during RUN and during DONE must be ignored.
      n0 = n_done;
      start_op(1'b0, 8'd6, 8'd7, 1'b1, 16'h002A);
      repeat (3) @(negedge clk);
      i_start = 1'b1;
      a       = 8'd9;
      b       = 8'd9;
      @(posedge clk);
      #1 i_start = 1'b0;
      wait_done();
      i_start = 1'b1;
      a       = 8'd9;
      b       = 8'd9;
      @(posedge clk);
      #1 i_start = 1'b0;
      repeat (15) @(negedge clk);
      check("ignored_starts_one_done", 64'(n_done - n0), 64'd1);
      start_op(1'b0, 8'd9, 8'd9, 1'b1, 16'h0051);
      wait_done();

      // Reset during the 4th RUN cycle aborts without a done.
      n0 = n_done;
      start_op(1'b0, 8'd200, 8'd3, 1'b0, '0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("abort_busy", {63'b0, busy}, 64'd0);
      check("abort_product", 64'(prod), 64'd0);
      check("abort_done", {63'b0, done}, 64'd0);
      repeat (15) @(negedge clk);
      check("abort_no_done", 64'(n_done - n0), 64'd0);
      start_op(1'b0, 8'd200, 8'd3, 1'b1, 16'h0258);
      wait_done();

      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom_range(0, 1));
         x = DW'($urandom);
         y = DW'($urandom);
         if (i % 8 == 0) x = 8'h80;
         if (i % 8 == 1) y = 8'h7F;
         start_op(s, x, y, 1'b1, model(s, x, y));
         wait_done();
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule
